// File: rtl/vrb_arbiter.sv
// vrb_arbiter: N-master to single-slave VRB command arbiter with in-order
// response routing. Commands pass through combinationally; the winning
// master index is queued so each slave response returns to its issuer.
module vrb_arbiter #(
    parameter int NM  = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int OSD = 4,
    parameter int RR  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NM-1:0]       i_m_cmd_valid,
    input  logic [NM*AW-1:0]    i_m_cmd_addr,
    input  logic [NM-1:0]       i_m_cmd_read,
    input  logic [NM*DW-1:0]    i_m_cmd_wdata,
    input  logic [NM*DW/8-1:0]  i_m_cmd_wmask,
    output logic [NM-1:0]       o_m_cmd_ready,
    output logic [NM-1:0]       o_m_rsp_valid,
    output logic                o_m_rsp_err,
    output logic [DW-1:0]       o_m_rsp_rdata,
    output logic                o_s_cmd_valid,
    output logic [AW-1:0]       o_s_cmd_addr,
    output logic                o_s_cmd_read,
    output logic [DW-1:0]       o_s_cmd_wdata,
    output logic [DW/8-1:0]     o_s_cmd_wmask,
    input  logic                i_s_cmd_ready,
    input  logic                i_s_rsp_valid,
    input  logic                i_s_rsp_err,
    input  logic [DW-1:0]       i_s_rsp_rdata,
    output logic                o_rsp_orphan
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int PW = (OSD > 1) ? $clog2(OSD) : 1;
    localparam int CW = $clog2(OSD + 1);
    localparam int MW = DW / 8;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t         state_reg, state_next;
    logic [IW-1:0]  lock_idx_reg, lock_idx_next;
    logic [IW-1:0]  p_reg, p_next;
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic           orphan_reg;

    // Small ID queue; read combinationally because responses route in the same cycle
    logic [IW-1:0]  id_mem [OSD];

    logic [IW-1:0]  arb_idx;
    logic           arb_found;
    logic [IW-1:0]  cand_idx;
    logic [IW-1:0]  grant_idx;
    logic           req_any;
    logic           full;
    logic           empty;
    logic           accept;
    logic           pop;
    logic [IW-1:0]  head_idx;

    // Per-master field views of the packed input buses
    logic [AW-1:0]  m_addr  [NM];
    logic [DW-1:0]  m_wdata [NM];
    logic [MW-1:0]  m_wmask [NM];

    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : g_unpack
            assign m_addr[gi]  = i_m_cmd_addr[gi*AW +: AW];
            assign m_wdata[gi] = i_m_cmd_wdata[gi*DW +: DW];
            assign m_wmask[gi] = i_m_cmd_wmask[gi*MW +: MW];
        end
    endgenerate

    // Free-running arbitration: first valid master searching from p (RR) or from 0 (fixed)
    always_comb begin
        arb_idx   = '0;
        arb_found = 1'b0;
        cand_idx  = '0;
        for (int off = 0; off < NM; off++) begin
            if (RR != 0) begin
                cand_idx = IW'((int'(p_reg) + off) % NM);
            end else begin
                cand_idx = IW'(off);
            end
            if (!arb_found && i_m_cmd_valid[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Once a command is presented but stalled, the grant stays on that master
    assign grant_idx = (state_reg == ST_LOCKED) ? lock_idx_reg : arb_idx;
    assign req_any   = (state_reg == ST_LOCKED) ? i_m_cmd_valid[lock_idx_reg] : arb_found;

    assign full   = (count_reg == CW'(OSD));
    assign empty  = (count_reg == '0);
    assign accept = o_s_cmd_valid && i_s_cmd_ready;
    assign pop    = i_s_rsp_valid && !empty;

    assign head_idx = id_mem[rd_ptr_reg];

    assign o_s_cmd_valid = req_any && !full;
    assign o_s_cmd_addr  = m_addr[grant_idx];
    assign o_s_cmd_read  = i_m_cmd_read[grant_idx];
    assign o_s_cmd_wdata = m_wdata[grant_idx];
    assign o_s_cmd_wmask = m_wmask[grant_idx];

    assign o_m_rsp_err   = i_s_rsp_err;
    assign o_m_rsp_rdata = i_s_rsp_rdata;
    assign o_rsp_orphan  = orphan_reg;

    generate
        for (gi = 0; gi < NM; gi++) begin : g_route
            assign o_m_cmd_ready[gi] = accept && (grant_idx == IW'(gi));
            assign o_m_rsp_valid[gi] = pop && (head_idx == IW'(gi));
        end
    endgenerate

    // Lock state machine and round-robin pointer update
    always_comb begin
        state_next    = state_reg;
        lock_idx_next = lock_idx_reg;
        p_next        = p_reg;
        case (state_reg)
            ST_IDLE: begin
                if (o_s_cmd_valid && !i_s_cmd_ready) begin
                    state_next    = ST_LOCKED;
                    lock_idx_next = arb_idx;
                end
            end
            ST_LOCKED: begin
                if (accept) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if ((RR != 0) && accept) begin
            p_next = (grant_idx == IW'(NM - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Control registers: state, lock index, pointer, ID queue bookkeeping, orphan pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            lock_idx_reg <= '0;
            p_reg        <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            orphan_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lock_idx_reg <= lock_idx_next;
            p_reg        <= p_next;
            if (accept) begin
                wr_ptr_reg <= (wr_ptr_reg == PW'(OSD - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(OSD - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            orphan_reg <= i_s_rsp_valid && empty;
        end
    end

    // ID queue storage: record the granted master on every accept
    always_ff @(posedge clk) begin
        if (accept) begin
            id_mem[wr_ptr_reg] <= grant_idx;
        end
    end

endmodule

// File: tb/tb_vrb_arbiter.sv
// tb_vrb_arbiter: scoreboard bench for vrb_arbiter (NM=2, OSD=4). A round-robin
// instance is checked through expectation queues drained by a monitor; a
// fixed-priority instance shares the stimulus and is checked directly.
module tb_vrb_arbiter;

    localparam int NM  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = DW / 8;
    localparam int OSD = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     i_m_cmd_valid;
    logic [NM*AW-1:0]  i_m_cmd_addr;
    logic [NM-1:0]     i_m_cmd_read;
    logic [NM*DW-1:0]  i_m_cmd_wdata;
    logic [NM*MW-1:0]  i_m_cmd_wmask;
    logic              i_s_cmd_ready;
    logic              i_s_rsp_valid;
    logic              i_s_rsp_err;
    logic [DW-1:0]     i_s_rsp_rdata;

    logic [NM-1:0]     o_m_cmd_ready, o_m_rsp_valid;
    logic              o_m_rsp_err;
    logic [DW-1:0]     o_m_rsp_rdata;
    logic              o_s_cmd_valid, o_s_cmd_read;
    logic [AW-1:0]     o_s_cmd_addr;
    logic [DW-1:0]     o_s_cmd_wdata;
    logic [MW-1:0]     o_s_cmd_wmask;
    logic              o_rsp_orphan;

    logic [NM-1:0]     fp_cmd_ready, fp_rsp_valid;
    logic              fp_rsp_err;
    logic [DW-1:0]     fp_rsp_rdata;
    logic              fp_cmd_valid, fp_cmd_read;
    logic [AW-1:0]     fp_cmd_addr;
    logic [DW-1:0]     fp_cmd_wdata;
    logic [MW-1:0]     fp_cmd_wmask;
    logic              fp_orphan;

    always #5 clk = ~clk;

    vrb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .OSD(OSD), .RR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_m_cmd_valid(i_m_cmd_valid), .i_m_cmd_addr(i_m_cmd_addr),
        .i_m_cmd_read(i_m_cmd_read), .i_m_cmd_wdata(i_m_cmd_wdata),
        .i_m_cmd_wmask(i_m_cmd_wmask), .o_m_cmd_ready(o_m_cmd_ready),
        .o_m_rsp_valid(o_m_rsp_valid), .o_m_rsp_err(o_m_rsp_err),
        .o_m_rsp_rdata(o_m_rsp_rdata), .o_s_cmd_valid(o_s_cmd_valid),
        .o_s_cmd_addr(o_s_cmd_addr), .o_s_cmd_read(o_s_cmd_read),
        .o_s_cmd_wdata(o_s_cmd_wdata), .o_s_cmd_wmask(o_s_cmd_wmask),
        .i_s_cmd_ready(i_s_cmd_ready), .i_s_rsp_valid(i_s_rsp_valid),
        .i_s_rsp_err(i_s_rsp_err), .i_s_rsp_rdata(i_s_rsp_rdata),
        .o_rsp_orphan(o_rsp_orphan)
    );

    vrb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .OSD(OSD), .RR(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_m_cmd_valid(i_m_cmd_valid), .i_m_cmd_addr(i_m_cmd_addr),
        .i_m_cmd_read(i_m_cmd_read), .i_m_cmd_wdata(i_m_cmd_wdata),
        .i_m_cmd_wmask(i_m_cmd_wmask), .o_m_cmd_ready(fp_cmd_ready),
        .o_m_rsp_valid(fp_rsp_valid), .o_m_rsp_err(fp_rsp_err),
        .o_m_rsp_rdata(fp_rsp_rdata), .o_s_cmd_valid(fp_cmd_valid),
        .o_s_cmd_addr(fp_cmd_addr), .o_s_cmd_read(fp_cmd_read),
        .o_s_cmd_wdata(fp_cmd_wdata), .o_s_cmd_wmask(fp_cmd_wmask),
        .i_s_cmd_ready(i_s_cmd_ready), .i_s_rsp_valid(i_s_rsp_valid),
        .i_s_rsp_err(i_s_rsp_err), .i_s_rsp_rdata(i_s_rsp_rdata),
        .o_rsp_orphan(fp_orphan)
    );

    // Fixed per-master command fields
    logic [AW-1:0] m_addr  [NM] = '{32'h1000_0040, 32'h2000_0080};
    logic [DW-1:0] m_wdata [NM] = '{32'hA0A0_0001, 32'hB1B1_0002};
    logic [MW-1:0] m_wmask [NM] = '{4'hF, 4'h3};
    logic          m_read  [NM] = '{1'b1, 1'b0};

    typedef struct {
        logic [NM-1:0] vec;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    int   cmd_q[$];
    rsp_t rsp_q[$];
    int   pending_orphans = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT shows an accept, a response or an orphan pulse
    always @(negedge clk) begin
        int   m;
        rsp_t r;
        if (o_s_cmd_valid && i_s_cmd_ready) begin
            if (cmd_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL cmd_unexpected: got ready=%b addr=%h expected no accept", o_m_cmd_ready, o_s_cmd_addr);
            end else begin
                m = cmd_q.pop_front();
                $display("t=%0t cmd accept m=%0d addr=%h read=%b", $time, m, o_s_cmd_addr, o_s_cmd_read);
                check("cmd_ready", 64'(o_m_cmd_ready), 64'(2'b01 << m));
                check("cmd_addr",  64'(o_s_cmd_addr),  64'(m_addr[m]));
                check("cmd_read",  64'(o_s_cmd_read),  64'(m_read[m]));
                check("cmd_wdata", 64'(o_s_cmd_wdata), 64'(m_wdata[m]));
                check("cmd_wmask", 64'(o_s_cmd_wmask), 64'(m_wmask[m]));
            end
        end
        if (|o_m_rsp_valid) begin
            if (rsp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b expected 00", o_m_rsp_valid);
            end else begin
                r = rsp_q.pop_front();
                $display("t=%0t rsp vec=%b rdata=%h err=%b", $time, o_m_rsp_valid, o_m_rsp_rdata, o_m_rsp_err);
                check("rsp_valid", 64'(o_m_rsp_valid), 64'(r.vec));
                check("rsp_rdata", 64'(o_m_rsp_rdata), 64'(r.rdata));
                check("rsp_err",   64'(o_m_rsp_err),   64'(r.err));
            end
        end
        if (o_rsp_orphan) begin
            n_checks++;
            if (pending_orphans == 0) begin
                n_errors++;
                $display("FAIL orphan_unexpected: got orphan=1 expected 0");
            end else begin
                pending_orphans--;
                $display("t=%0t orphan pulse", $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NM-1:0] v, input logic rdy, input logic rv,
                         input logic [DW-1:0] rd, input logic re);
        i_m_cmd_valid = v;
        i_s_cmd_ready = rdy;
        i_s_rsp_valid = rv;
        i_s_rsp_rdata = rd;
        i_s_rsp_err   = re;
    endtask

    task automatic exp_rsp(input logic [NM-1:0] vec, input logic [DW-1:0] rd, input logic re);
        rsp_t r;
        r.vec   = vec;
        r.rdata = rd;
        r.err   = re;
        rsp_q.push_back(r);
    endtask

    initial begin
        rst_n         = 1'b0;
        i_m_cmd_addr  = '0;
        i_m_cmd_read  = '0;
        i_m_cmd_wdata = '0;
        i_m_cmd_wmask = '0;
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        tick();
        tick();
        // Reset state with all inputs zero
        @(negedge clk);
        check("rst_s_valid",   64'(o_s_cmd_valid), 64'd0);
        check("rst_cmd_ready", 64'(o_m_cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(o_m_rsp_valid), 64'd0);
        check("rst_orphan",    64'(o_rsp_orphan),  64'd0);
        check("rst_addr",      64'(o_s_cmd_addr),  64'd0);
        check("rst_fp_valid",  64'(fp_cmd_valid),  64'd0);
        tick();
        for (int k = 0; k < NM; k++) begin
            i_m_cmd_addr[k*AW +: AW]  = m_addr[k];
            i_m_cmd_wdata[k*DW +: DW] = m_wdata[k];
            i_m_cmd_wmask[k*MW +: MW] = m_wmask[k];
            i_m_cmd_read[k]           = m_read[k];
        end
        rst_n = 1'b1;
        tick();

        // Round-robin alternation, fills the 4-deep queue
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
            cmd_q.push_back(c % 2);
            tick();
        end
        // Full: fifth request is held off
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("full_blocks", 64'(o_s_cmd_valid), 64'd0);
        tick();
        // Pop while full: push still blocked this cycle
        drive(2'b01, 1'b1, 1'b1, 32'h11, 1'b0);
        exp_rsp(2'b01, 32'h11, 1'b0);
        @(negedge clk);
        check("full_pop_blocks", 64'(o_s_cmd_valid), 64'd0);
        tick();
        // Next cycle the request goes through
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0);
        cmd_q.push_back(0);
        tick();
        // Drain in command order: m1,m0,m1,m0
        for (int c = 0; c < 4; c++) begin
            drive(2'b00, 1'b0, 1'b1, 32'h21 + c, 1'b0);
            exp_rsp((c % 2 == 0) ? 2'b10 : 2'b01, 32'h21 + c, 1'b0);
            tick();
        end
        // Orphan response on empty queue
        drive(2'b00, 1'b0, 1'b1, 32'hDEAD, 1'b0);
        pending_orphans++;
        @(negedge clk);
        check("orphan_no_route", 64'(o_m_rsp_valid), 64'd0);
        tick();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        tick();

        // Ordered responses: accepts m1,m0,m1 then rdata A,B,C
        drive(2'b10, 1'b1, 1'b0, '0, 1'b0); cmd_q.push_back(1); tick();
        drive(2'b01, 1'b1, 1'b0, '0, 1'b0); cmd_q.push_back(0); tick();
        drive(2'b10, 1'b1, 1'b0, '0, 1'b0); cmd_q.push_back(1); tick();
        drive(2'b00, 1'b0, 1'b1, 32'hA, 1'b0); exp_rsp(2'b10, 32'hA, 1'b0); tick();
        drive(2'b00, 1'b0, 1'b1, 32'hB, 1'b1); exp_rsp(2'b01, 32'hB, 1'b1); tick();
        drive(2'b00, 1'b0, 1'b1, 32'hC, 1'b0); exp_rsp(2'b10, 32'hC, 1'b0); tick();

        // Lock: m1 stalled, m0 rises, grant stays on m1 until accept
        drive(2'b10, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("lock_valid", 64'(o_s_cmd_valid), 64'd1);
        check("lock_no_ready", 64'(o_m_cmd_ready), 64'd0);
        tick();
        for (int c = 0; c < 2; c++) begin
            drive(2'b11, 1'b0, 1'b0, '0, 1'b0);
            @(negedge clk);
            check("lock_hold_addr", 64'(o_s_cmd_addr), 64'(m_addr[1]));
            tick();
        end
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0); cmd_q.push_back(1); tick();
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0); cmd_q.push_back(0); tick();
        drive(2'b00, 1'b0, 1'b1, 32'h31, 1'b0); exp_rsp(2'b10, 32'h31, 1'b0); tick();
        drive(2'b00, 1'b0, 1'b1, 32'h32, 1'b0); exp_rsp(2'b01, 32'h32, 1'b0); tick();

        // Locked master drops valid: slave valid follows it, not the other master
        drive(2'b10, 1'b0, 1'b0, '0, 1'b0); tick();
        drive(2'b01, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("lock_drop_valid", 64'(o_s_cmd_valid), 64'd0);
        tick();
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0); cmd_q.push_back(1); tick();
        drive(2'b00, 1'b0, 1'b1, 32'h41, 1'b0); exp_rsp(2'b10, 32'h41, 1'b0); tick();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0); tick();

        // Reset mid-transaction: the pre-reset command's response becomes an orphan
        drive(2'b11, 1'b1, 1'b0, '0, 1'b0); cmd_q.push_back(0); tick();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_s_valid",   64'(o_s_cmd_valid), 64'd0);
        check("midrst_rsp_valid", 64'(o_m_rsp_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(2'b00, 1'b0, 1'b1, 32'h55, 1'b0);
        pending_orphans++;
        @(negedge clk);
        check("post_rst_orphan_route", 64'(o_m_rsp_valid), 64'd0);
        tick();
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0); tick();

        // Fixed priority vs round-robin on the same traffic
        for (int c = 0; c < 3; c++) begin
            drive(2'b11, 1'b1, 1'b0, '0, 1'b0);
            cmd_q.push_back(c % 2);
            @(negedge clk);
            check("fp_ready", 64'(fp_cmd_ready), 64'(2'b01));
            check("fp_addr",  64'(fp_cmd_addr),  64'(m_addr[0]));
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            drive(2'b00, 1'b0, 1'b1, 32'h61 + c, 1'b0);
            exp_rsp((c % 2 == 0) ? 2'b01 : 2'b10, 32'h61 + c, 1'b0);
            @(negedge clk);
            check("fp_rsp_valid", 64'(fp_rsp_valid), 64'(2'b01));
            tick();
        end
        drive(2'b00, 1'b0, 1'b0, '0, 1'b0);
        tick();
        tick();

        // Every expected event must have been observed
        check("cmd_q_left",     64'(cmd_q.size()),   64'd0);
        check("rsp_q_left",     64'(rsp_q.size()),   64'd0);
        check("orphans_left",   64'(pending_orphans), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
